ifft_engine: RTL
================

IFFT_ENGINE -- requirements
Module: ifft_engine

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, the sample width in bits of each signed Q8.8 real or imaginary component.
REQ-002 The block SHALL have clk  input  1  clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have in_valid  input  1  frequency-domain frame present on the X_* inputs.
REQ-005 The block SHALL have in_ready  output  1  block can accept a frame this cycle.
REQ-006 The block SHALL have X_re_in  input  4*WIDTH  signed real parts X[0..3], where lane k is bits [k*WIDTH +: WIDTH].
REQ-007 The block SHALL have X_im_in  input  4*WIDTH  signed imaginary parts, packed with the same lane layout as X_re_in.
REQ-008 The block SHALL have out_valid  output  1  time-domain frame present on the x_* outputs.
REQ-009 The block SHALL have out_ready  input  1  downstream consumer accepts the frame.
REQ-010 The block SHALL have x_re_out  output  4*WIDTH  signed real parts x[0..3], packed with the same lane layout as X_re_in.
REQ-011 The block SHALL have x_im_out  output  4*WIDTH  signed imaginary parts, packed with the same lane layout as X_re_in.

Function
REQ-012 The block SHALL compute the 4-point inverse DFT x[n] = (1/4) * sum over k of X[k]*e^(+j*2*pi*k*n/4), using two radix-2 decimation-in-time stages and no multipliers.
REQ-013 Stage 1 SHALL compute a0=(X0+X2)/2, a1=(X0-X2)/2, b0=(X1+X3)/2 and b1=(X1-X3)/2, separately on the real and imaginary parts.
REQ-014 Stage 2 SHALL compute x0=(a0+b0)/2, x2=(a0-b0)/2, x1=(a1+j*b1)/2 and x3=(a1-j*b1)/2, where j*(re,im)=(-im,re).
REQ-015 Each add or subtract SHALL be formed at WIDTH+1 bits, then arithmetically shifted right by 1 (floor) and kept as the low WIDTH bits; no overflow is possible and no saturation is needed.
REQ-016 The FSM SHALL have four states: IDLE, STAGE1, STAGE2 and OUT.
REQ-017 In IDLE, in_ready SHALL be 1; when in_valid=1, the block SHALL register all eight input lanes and go to STAGE1.
REQ-018 In IDLE with in_valid=0, the block SHALL stay in IDLE.
REQ-019 In STAGE1, the block SHALL load the stage-1 registers and go to STAGE2 unconditionally.
REQ-020 In STAGE2, the block SHALL load the output registers and go to OUT unconditionally.
REQ-021 In OUT, out_valid SHALL be 1; when out_ready=1, the block SHALL go to IDLE in the next cycle, otherwise it SHALL stay in OUT.
REQ-022 in_ready SHALL be 0 in STAGE1, STAGE2 and OUT, and in_valid SHALL be ignored in those states.
REQ-023 Latency SHALL be 3 cycles: a frame accepted in cycle c produces out_valid=1 in cycle c+3.
REQ-024 Throughput SHALL be at most one frame per 4 cycles, with no input-to-output overlap.
REQ-025 While in OUT with out_ready=0, x_re_out and x_im_out SHALL hold stable.
REQ-026 After the output handshake, x_re_out and x_im_out SHALL retain their last values until the next STAGE2 load.
REQ-027 in_ready and out_valid SHALL be decoded combinationally from the state register only, never from in_valid or out_ready.
REQ-028 out_ready sampled while out_valid=0 SHALL have no effect.

Reset
REQ-029 When rst=1 at a clock edge, the block SHALL enter IDLE regardless of state, including mid-STAGE1, mid-STAGE2 or in OUT.
REQ-030 When rst=1 at a clock edge, the block SHALL clear the input, stage-1 and output registers to 0.
REQ-031 After reset, out_valid SHALL be 0, in_ready SHALL be 1, and x_re_out=x_im_out=0.
REQ-032 A frame in flight at reset SHALL be discarded and no out_valid pulse SHALL be produced for it.

Verification
REQ-033 The bench SHALL drive X_re={0x0400,0,0,0} with X_im=0 and check that all x_re lanes =0x0100, x_im=0, and out_valid rises exactly 3 cycles after acceptance.
REQ-034 The bench SHALL drive X_re={0x0100,0x0100,0x0100,0x0100} with X_im=0 and check x_re={0x0100,0,0,0} and x_im=0.
REQ-035 The bench SHALL drive X_re[1]=0x0400 with all other inputs 0 and check x_re={0x0100,0,0xFF00,0} and x_im={0,0x0100,0,0xFF00}.
REQ-036 The bench SHALL cover the extremes: all X_re=0x7FFF must give x_re={0x7FFF,0,0,0}, and X_re[0]=0xFFFF with all others 0 must give all x_re=0xFFFF with x_im=0.
REQ-037 The bench SHALL hold out_ready=0 for 5 cycles in OUT while pulsing in_valid, and check that out_valid stays 1, outputs are stable, in_ready=0, and no second frame is captured; it SHALL then raise out_ready and check that IDLE and in_ready=1 follow one cycle later.
REQ-038 The bench SHALL assert rst for 1 cycle during STAGE1 and check outputs =0, out_valid=0 and in_ready=1 on the next cycle, with no out_valid for the aborted frame.

Source files
------------

// File: rtl/ifft_engine.sv
// ---------------------------------------------------------------------------
// ifft_engine
//   4-point inverse DFT on signed Q8.8 complex samples, built from two
//   radix-2 decimation-in-time butterfly stages using only adders and
//   shifts. Every add/subtract halves its result, which realises the 1/4
//   scale factor across the two stages and keeps the values in range.
//   A four-state FSM (IDLE -> STAGE1 -> STAGE2 -> OUT) sequences one frame
//   at a time.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   frequency-domain frame present on X_re_in / X_im_in
//   in_ready   block can accept a frame this cycle (IDLE)
//   X_re_in    X[0..3] real parts, lane k = bits [k*WIDTH +: WIDTH]
//   X_im_in    X[0..3] imaginary parts, same lane layout
//   out_valid  time-domain frame present on x_re_out / x_im_out (OUT)
//   out_ready  downstream consumer accepts the frame
//   x_re_out   x[0..3] real parts, same lane layout
//   x_im_out   x[0..3] imaginary parts, same lane layout
// ---------------------------------------------------------------------------
module ifft_engine #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*WIDTH-1:0]   X_re_in,
  input  logic [4*WIDTH-1:0]   X_im_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*WIDTH-1:0]   x_re_out,
  output logic [4*WIDTH-1:0]   x_im_out
);

  typedef enum logic [1:0] {IDLE, STAGE1, STAGE2, OUT} state_t;

  state_t r_state;

  logic signed [WIDTH-1:0] r_xre_p0 [4];
  logic signed [WIDTH-1:0] r_xim_p0 [4];
  // index 0 holds the sum butterfly output, index 1 the difference
  logic signed [WIDTH-1:0] r_are_p1 [2];
  logic signed [WIDTH-1:0] r_aim_p1 [2];
  logic signed [WIDTH-1:0] r_bre_p1 [2];
  logic signed [WIDTH-1:0] r_bim_p1 [2];
  logic signed [WIDTH-1:0] r_yre_p2 [4];
  logic signed [WIDTH-1:0] r_yim_p2 [4];

  // (a+b)/2 with one guard bit; floor shift keeps the result in WIDTH bits
  function automatic logic signed [WIDTH-1:0] half_add(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    logic signed [WIDTH:0] s;
    s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    return s[WIDTH:1];
  endfunction

  // (a-b)/2 with one guard bit
  function automatic logic signed [WIDTH-1:0] half_sub(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    logic signed [WIDTH:0] s;
    s = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    return s[WIDTH:1];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      for (int k = 0; k < 4; k++) begin
        r_xre_p0[k] <= '0;
        r_xim_p0[k] <= '0;
        r_yre_p2[k] <= '0;
        r_yim_p2[k] <= '0;
      end
      for (int k = 0; k < 2; k++) begin
        r_are_p1[k] <= '0;
        r_aim_p1[k] <= '0;
        r_bre_p1[k] <= '0;
        r_bim_p1[k] <= '0;
      end
    end else begin
      case (r_state)
        // input capture (p0)
        IDLE: begin
          if (in_valid) begin
            for (int k = 0; k < 4; k++) begin
              r_xre_p0[k] <= X_re_in[k*WIDTH +: WIDTH];
              r_xim_p0[k] <= X_im_in[k*WIDTH +: WIDTH];
            end
            r_state <= STAGE1;
          end
        end
        // stage 1 butterflies: even pair (X0,X2) -> a, odd pair (X1,X3) -> b
        STAGE1: begin
          r_are_p1[0] <= half_add(r_xre_p0[0], r_xre_p0[2]);
          r_aim_p1[0] <= half_add(r_xim_p0[0], r_xim_p0[2]);
          r_are_p1[1] <= half_sub(r_xre_p0[0], r_xre_p0[2]);
          r_aim_p1[1] <= half_sub(r_xim_p0[0], r_xim_p0[2]);
          r_bre_p1[0] <= half_add(r_xre_p0[1], r_xre_p0[3]);
          r_bim_p1[0] <= half_add(r_xim_p0[1], r_xim_p0[3]);
          r_bre_p1[1] <= half_sub(r_xre_p0[1], r_xre_p0[3]);
          r_bim_p1[1] <= half_sub(r_xim_p0[1], r_xim_p0[3]);
          r_state     <= STAGE2;
        end
        // stage 2 butterflies (p2); twiddle +j maps (re,im) to (-im,re)
        STAGE2: begin
          r_yre_p2[0] <= half_add(r_are_p1[0], r_bre_p1[0]);
          r_yim_p2[0] <= half_add(r_aim_p1[0], r_bim_p1[0]);
          r_yre_p2[2] <= half_sub(r_are_p1[0], r_bre_p1[0]);
          r_yim_p2[2] <= half_sub(r_aim_p1[0], r_bim_p1[0]);
          r_yre_p2[1] <= half_sub(r_are_p1[1], r_bim_p1[1]);
          r_yim_p2[1] <= half_add(r_aim_p1[1], r_bre_p1[1]);
          r_yre_p2[3] <= half_add(r_are_p1[1], r_bim_p1[1]);
          r_yim_p2[3] <= half_sub(r_aim_p1[1], r_bre_p1[1]);
          r_state     <= OUT;
        end
        OUT: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == OUT);

  always_comb begin
    x_re_out = '0;
    x_im_out = '0;
    for (int k = 0; k < 4; k++) begin
      x_re_out[k*WIDTH +: WIDTH] = r_yre_p2[k];
      x_im_out[k*WIDTH +: WIDTH] = r_yim_p2[k];
    end
  end

endmodule
